// File: rtl/weight_stationary_systolic_array.sv
// Weight-stationary systolic matrix-vector engine with double-buffered weights,
// internal input skew / output deskew and a valid-tagged fixed-latency pipeline.
module weight_stationary_systolic_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(ROWS)+1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*DATA_WIDTH-1:0]     data_in,
    input  logic                           data_valid,
    input  logic [COLUMNS*DATA_WIDTH-1:0]  weight_in,
    input  logic                           weight_valid,
    output logic                           weight_ready,
    input  logic                           weight_swap,
    input  logic                           signed_mode,
    output logic                           swap_ready,
    output logic                           busy,
    output logic [COLUMNS*ACC_WIDTH-1:0]   result,
    output logic                           result_valid
);
    localparam int LAT   = ROWS + COLUMNS - 1;
    localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(LAT + 2);
    localparam int EXT_W = ACC_WIDTH - DATA_WIDTH;

    logic [DATA_WIDTH-1:0] shadow_w [ROWS][COLUMNS];
    logic [DATA_WIDTH-1:0] active_w [ROWS][COLUMNS];
    logic [PTR_W-1:0]      ptr;
    logic                  shadow_full;
    logic                  mode_q;
    logic                  mode_use;
    logic                  load_fire;
    logic                  swap_fire;
    logic [LAT-1:0]        vld;
    logic [CNT_W-1:0]      inflight;

    logic [DATA_WIDTH-1:0] a_pass [ROWS][COLUMNS];
    logic [ACC_WIDTH-1:0]  p_out  [ROWS][COLUMNS];
    logic [ACC_WIDTH-1:0]  col_out [COLUMNS];

    assign weight_ready = !shadow_full;
    assign busy         = inflight != '0;
    assign swap_ready   = shadow_full && !busy;
    assign load_fire    = weight_valid && weight_ready;
    assign swap_fire    = weight_swap && swap_ready;
    // A beat accepted on the swap edge must already see the new mode/weights
    assign mode_use     = swap_fire ? signed_mode : mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLUMNS; c++) begin
                    shadow_w[r][c] <= '0;
                    active_w[r][c] <= '0;
                end
            end
            ptr         <= '0;
            shadow_full <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            if (load_fire) begin
                for (int c = 0; c < COLUMNS; c++) begin
                    shadow_w[ptr][c] <= weight_in[c*DATA_WIDTH +: DATA_WIDTH];
                end
                if (ptr == PTR_W'(ROWS - 1)) begin
                    ptr         <= '0;
                    shadow_full <= 1'b1;
                end else begin
                    ptr <= ptr + PTR_W'(1);
                end
            end
            if (swap_fire) begin
                active_w    <= shadow_w;
                mode_q      <= signed_mode;
                shadow_full <= 1'b0;
            end
        end
    end

    // Row r sees its element r cycles late so wavefronts line up diagonally
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_pass
            assign a_pass[r][0] = data_in[0 +: DATA_WIDTH];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] sr [r];
            always_ff @(posedge clk) begin
                sr[0] <= data_in[r*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k < r; k++) begin
                    sr[k] <= sr[k-1];
                end
            end
            assign a_pass[r][0] = sr[r-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLUMNS; c++) begin : g_pe
            logic [DATA_WIDTH-1:0] w;
            logic [ACC_WIDTH-1:0]  ea;
            logic [ACC_WIDTH-1:0]  ew;
            logic [ACC_WIDTH-1:0]  p_in;
            logic [ACC_WIDTH-1:0]  ps_q;

            assign w  = swap_fire ? shadow_w[r][c] : active_w[r][c];
            assign ea = {{EXT_W{mode_use & a_pass[r][c][DATA_WIDTH-1]}},
                         a_pass[r][c]};
            assign ew = {{EXT_W{mode_use & w[DATA_WIDTH-1]}}, w};

            if (r == 0) begin : g_top
                assign p_in = '0;
            end else begin : g_mid
                assign p_in = p_out[r-1][c];
            end

            always_ff @(posedge clk) begin
                ps_q <= p_in + ea * ew;
            end
            assign p_out[r][c] = ps_q;

            if (c < COLUMNS - 1) begin : g_fwd
                logic [DATA_WIDTH-1:0] a_q;
                always_ff @(posedge clk) begin
                    a_q <= a_pass[r][c];
                end
                assign a_pass[r][c+1] = a_q;
            end
        end
    end

    // Earlier columns finish first; delay them to meet the last column
    for (genvar c = 0; c < COLUMNS; c++) begin : g_deskew
        localparam int D = COLUMNS - 1 - c;
        if (D == 0) begin : g_none
            assign col_out[c] = p_out[ROWS-1][c];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] dq [D];
            always_ff @(posedge clk) begin
                dq[0] <= p_out[ROWS-1][c];
                for (int k = 1; k < D; k++) begin
                    dq[k] <= dq[k-1];
                end
            end
            assign col_out[c] = dq[D-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld          <= '0;
            inflight     <= '0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            vld          <= LAT'({vld, data_valid});
            result_valid <= vld[LAT-1];
            if (vld[LAT-1]) begin
                for (int c = 0; c < COLUMNS; c++) begin
                    result[c*ACC_WIDTH +: ACC_WIDTH] <= col_out[c];
                end
            end
            unique case ({data_valid, vld[LAT-1]})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: doc/weight_stationary_systolic_array.md
Name: weight_stationary_systolic_array

Overview:
Parametrised ROWS x COLUMNS weight-stationary systolic matrix-vector engine, successor to the monodirectional array.
Adds a double-buffered weight store (shadow rows load while the active set computes) and a signed/unsigned mode.
Adds internal input skew and output deskew so callers present and receive whole aligned vectors, a valid-tagged fully pipelined datapath, and configurable accumulator width.
Sits between the activation/weight feeders and the accumulator buffers in the core.

Parameters:
DATA_WIDTH, 8, width of each data and weight element
ROWS, 4, number of PE rows; one data element per row per beat
COLUMNS, 4, number of PE columns; one result element per column
ACC_WIDTH, 2*DATA_WIDTH+$clog2(ROWS)+1, accumulator/result element width; must be >= 2*DATA_WIDTH

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
data_in  in  ROWS*DATA_WIDTH  input vector; element r at [r*DATA_WIDTH +: DATA_WIDTH]
data_valid  in  1  data_in accepted this cycle; no backpressure
weight_in  in  COLUMNS*DATA_WIDTH  one weight row; element c at [c*DATA_WIDTH +: DATA_WIDTH]
weight_valid  in  1  weight row beat; accepted only when weight_ready=1
weight_ready  out  1  shadow buffer not full
weight_swap  in  1  request to promote shadow weights to active; honoured only when swap_ready=1
signed_mode  in  1  sampled at swap; 1 = two's-complement operands, 0 = unsigned
swap_ready  out  1  shadow_full && !busy
busy  out  1  at least one accepted beat has not yet produced its result
result  out  COLUMNS*ACC_WIDTH  output vector; element c at [c*ACC_WIDTH +: ACC_WIDTH]
result_valid  out  1  result holds a complete aligned vector this cycle

Behaviour:
- Reset:
  - Clears active and shadow weights, row pointer, shadow_full, latched mode (unsigned), every pipeline valid bit and the in-flight counter.
  - Outputs after reset: weight_ready=1, swap_ready=0, busy=0, result_valid=0, result=0.
  - Reset mid-stream discards all in-flight beats; no result_valid after release for beats accepted before reset.
- Weight load:
  - Each weight_valid && weight_ready writes weight_in to shadow row[ptr], then ptr++.
  - On the ROWS-th beat: ptr wraps to 0, shadow_full=1, weight_ready=0 from the next cycle.
  - weight_valid while weight_ready=0 is ignored.
- Swap:
  - weight_swap && swap_ready: active <= shadow and mode <= signed_mode at that edge; shadow_full=0.
  - weight_swap otherwise is ignored; no pending request is stored.
  - Shadow loading is permitted while busy; only the swap waits for drain.
- Data path:
  - Row r data delayed r cycles (skew) and then passed rightward PE to PE.
  - Partial sums flow downward; column c output delayed COLUMNS-1-c cycles (deskew).
  - Fixed latency: beat accepted at edge t gives result_valid=1 in the cycle after edge t+ROWS+COLUMNS-1, i.e. ROWS+COLUMNS cycles.
  - Back-to-back beats give back-to-back results, one per cycle, order preserved.
- Data and swap in the same cycle: swap requires !busy and takes effect at that edge; the beat accepted at the same edge uses the NEW weights and mode. busy rises the following cycle.
- Arithmetic:
  - result[c] = sum over r of data[r]*active_weight[r][c].
  - Operands are sign- or zero-extended per latched mode to ACC_WIDTH.
  - Products and sums wrap modulo 2^ACC_WIDTH; no saturation.
- busy: in-flight counter +1 on accept, -1 on result_valid, simultaneous events net 0; busy = counter != 0.
- result holds its last value when result_valid=0.

Test Plan (ROWS=COLUMNS=2, DATA_WIDTH=8, ACC_WIDTH=18):
1. Reset: assert rst mid-cycle -> immediately weight_ready=1, busy=0, swap_ready=0, result_valid=0, result=0.
2. Unsigned, single beat:
   - Load rows [1,2],[3,4], swap with signed_mode=0; data [5,6] at edge t.
   - result_valid exactly 4 cycles later; col0=23, col1=34; busy falls the same cycle.
3. Signed mode:
   - Weights [-1,2],[3,-4] (0xFF,0x02 / 0x03,0xFC), signed_mode=1, data [-5,6].
   - col0=23, col1=-34 (0x3FFDE).
   - Repeat unsigned with weights [255,1],[255,1], data [255,255] -> col0=130050, col1=510.
4. Streaming:
   - Three consecutive beats [1,0],[0,1],[1,1] with weights [1,2],[3,4] -> three consecutive results [1,2],[3,4],[4,6].
   - weight_swap asserted while busy is ignored; old weights are kept.
5. Shadow load overlap:
   - During streaming, send 3 weight beats; third is dropped and weight_ready=0 after the second.
   - swap_ready rises only when busy falls; after swap, data [1,1] reflects the new weights.
   - Data accepted the same cycle as the swap uses the new weights.
6. Reset mid-stream: 2 beats in flight, pulse rst -> no result_valid for 8 cycles after release; shadow/active weights read back as 0 (data [1,1] -> [0,0]).
